dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit words in the storage array.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states between request acceptance and response; legal range 0..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = word write, 0 = word read.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  write data.
REQ-010 resp_valid  output  1  response present.
REQ-011 resp_ready  input  1  initiator accepts the response this cycle.
REQ-012 resp_rdata  output  32  read data; 0 for writes and errors.
REQ-013 resp_err  output  1  request was misaligned or out of range.

Function
REQ-014 The FSM SHALL have three states, IDLE, WAIT and RESP, with the following transitions:
- IDLE to WAIT on accept when WAIT_CYCLES > 0.
- IDLE to RESP on accept when WAIT_CYCLES = 0.
- WAIT to RESP when the wait counter is 0.
- RESP to IDLE on resp_valid && resp_ready.
REQ-015 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with req_valid && req_ready.
REQ-016 On accept, the block SHALL register req_we, req_addr and req_wdata and load the wait counter with WAIT_CYCLES-1.
REQ-017 The wait counter SHALL decrement by 1 each cycle in WAIT and never wrap below 0.
REQ-018 Latency: for an accept on cycle T, resp_valid SHALL rise on cycle T+1+WAIT_CYCLES.
REQ-019 resp_valid SHALL be 1 only in RESP; resp_rdata and resp_err SHALL stay stable while resp_valid=1 and resp_ready=0.
REQ-020 A request SHALL be flagged as an error when addr[1:0] != 0 or addr[31:2] >= DEPTH.
REQ-021 An error request SHALL return resp_err=1 and resp_rdata=0, and SHALL NOT modify storage.
REQ-022 A legal write SHALL update word addr[31:2] on the clock edge that enters RESP; its response SHALL have resp_rdata=0 and resp_err=0.
REQ-023 A legal read SHALL capture word addr[31:2] on the clock edge that enters RESP; a write to the same word earlier in a completed transaction SHALL be visible.
REQ-024 A request presented while not in IDLE SHALL be ignored; the initiator holds it until req_ready=1.
REQ-025 A response accepted in RESP SHALL return the FSM to IDLE; req_ready SHALL be 1 on the next cycle, giving a minimum of 2+WAIT_CYCLES cycles between accepts.
REQ-026 resp_ready asserted outside RESP SHALL have no effect.

Reset
REQ-027 While reset=1, the block SHALL force:
- FSM to IDLE, wait counter to 0, registered request to 0.
- req_ready=1 (combinational from IDLE).
- resp_valid=0, resp_rdata=0, resp_err=0.
REQ-028 Reset asserted in WAIT or RESP SHALL abort the transaction; a pending write SHALL NOT reach storage.
REQ-029 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-030 The state enum (IDLE, WAIT, RESP) and the WAIT counter width constant (4) SHALL live in a shared package, mem_pkg.
REQ-031 Storage SHALL be a sub-module, dmem_array: a synchronous-write, combinational-read word array with ports clk, we, word address and wdata, and output rdata.
REQ-032 dmem_responder SHALL contain only the FSM, counter, request registers, error decode and response registers.

Verification
REQ-033 Scenario, WAIT_CYCLES=2: write 0xDEADBEEF to address 0x10, accepted on cycle T -> resp_valid at T+3, resp_err=0, resp_rdata=0; then read 0x10 -> resp_rdata=0xDEADBEEF.
REQ-034 Scenario, misaligned: write to address 0x12 -> resp_err=1, resp_rdata=0; a subsequent read of 0x10 still returns its prior value.
REQ-035 Scenario, out of range with DEPTH=64: read address 0x100 -> resp_err=1, resp_rdata=0.
REQ-036 Scenario, backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_rdata and resp_err stable, req_ready=0; release -> IDLE with req_ready=1 the next cycle.
REQ-037 Scenario, reset mid-operation: accept a write of 0x12345678 to 0x20, then assert reset in WAIT -> all outputs at reset values immediately; a later read of 0x20 returns the old value.
REQ-038 Scenario, WAIT_CYCLES=0: back-to-back reads with resp_ready=1 -> resp_valid at T+1, accepts spaced exactly 2 cycles apart.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int unsigned CNT_W = 4;

    // Wait-counter preload; a zero-wait build never enters WAIT, so the value is moot there.
    function automatic logic [CNT_W-1:0] cnt_load(input int unsigned waits);
        return (waits > 0) ? CNT_W'(waits - 1) : '0;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write, combinational read, no reset.
module dmem_array #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding memory responder: request capture, wait states, error decode
// and a registered response held under backpressure.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned    AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = cnt_load(WAIT_CYCLES);
    localparam logic           NO_WAIT  = (WAIT_CYCLES == 0);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;

    logic             cur_we;
    logic [31:0]      cur_addr;
    logic [31:0]      cur_wdata;
    logic             cur_err;
    logic             enter_resp;
    logic             mem_we;
    logic [31:0]      mem_rdata;

    // With no wait states RESP is entered on the accept edge itself, before the
    // request registers are loaded, so the live request feeds storage and decode in IDLE.
    always_comb begin
        cur_we    = we_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        if (state == IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end
    end

    assign cur_err    = (cur_addr[1:0] != 2'b00) || (cur_addr[31:2] >= 30'(DEPTH));
    assign enter_resp = ((state == IDLE) && req_valid && NO_WAIT)
                     || ((state == WAIT) && (cnt == '0));
    assign mem_we     = enter_resp && cur_we && !cur_err && !reset;
    assign req_ready  = (state == IDLE);

    dmem_array #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .addr (cur_addr[AW+1:2]),
        .wdata(cur_wdata),
        .rdata(mem_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt     <= CNT_LOAD;
                        state   <= NO_WAIT ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (enter_resp) begin
                resp_valid <= 1'b1;
                resp_err   <= cur_err;
                resp_rdata <= (cur_we || cur_err) ? '0 : mem_rdata;
            end else if ((state == RESP) && resp_ready) begin
                resp_valid <= 1'b0;
                resp_rdata <= '0;
                resp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: a zero-wait and a two-wait responder driven by directed requests.
module tb_dmem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned t;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int unsigned cyc = 0;

    logic        rv     [2];
    logic        rwe    [2];
    logic [31:0] raddr  [2];
    logic [31:0] rwd    [2];
    logic        rrdy   [2];
    logic        req_ready  [2];
    logic        resp_valid [2];
    logic        resp_err   [2];
    logic [31:0] resp_rdata [2];

    exp_t q0[$];
    exp_t q1[$];
    bit   seen [2];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(rv[0]), .req_ready(req_ready[0]), .req_we(rwe[0]),
        .req_addr(raddr[0]), .req_wdata(rwd[0]),
        .resp_valid(resp_valid[0]), .resp_ready(rrdy[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset),
        .req_valid(rv[1]), .req_ready(req_ready[1]), .req_we(rwe[1]),
        .req_addr(raddr[1]), .req_wdata(rwd[1]),
        .resp_valid(resp_valid[1]), .resp_ready(rrdy[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
        end
    endtask

    task automatic mon(input int d);
        exp_t        e;
        int unsigned lat;
        int          n;
        lat = (d == 0) ? 1 : 3;
        if (reset || !resp_valid[d]) return;
        n = (d == 0) ? q0.size() : q1.size();
        if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp dut%0d: got resp_valid=1 expected no response", d);
            return;
        end
        if (d == 0) e = q0[0];
        else        e = q1[0];
        if (!seen[d]) begin
            chk("latency", d, cyc - e.t, lat);
            seen[d] = 1'b1;
        end
        chk("resp_rdata", d, resp_rdata[d], e.rdata);
        chk("resp_err", d, 32'(resp_err[d]), 32'(e.err));
        chk("req_ready_busy", d, 32'(req_ready[d]), 32'd0);
        if (rrdy[d]) begin
            if (d == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
            seen[d] = 1'b0;
        end
    endtask

    always @(negedge clk) mon(0);
    always @(negedge clk) mon(1);

    // Presents a request (called just after a rising edge) and returns its accept cycle.
    task automatic do_req(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err, output int unsigned t_acc);
        exp_t e;
        int   n;
        rv[d] = 1'b1; rwe[d] = we; raddr[d] = a; rwd[d] = wd;
        n = 0;
        t_acc = 0;
        forever begin
            @(negedge clk);
            if (req_ready[d] && !reset) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL req_timeout dut%0d: got req_ready=0 for 50 cycles expected 1", d);
                rv[d] = 1'b0;
                return;
            end
        end
        e.rdata = exp_rd; e.err = exp_err; e.t = cyc;
        t_acc = cyc;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        @(posedge clk); #1;
        rv[d] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q0.size() != 0 || q1.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
                q0.delete();
                q1.delete();
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_outputs(input int d);
        chk("rst_req_ready", d, 32'(req_ready[d]), 32'd1);
        chk("rst_resp_valid", d, 32'(resp_valid[d]), 32'd0);
        chk("rst_resp_rdata", d, resp_rdata[d], 32'd0);
        chk("rst_resp_err", d, 32'(resp_err[d]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        int unsigned t, t1, t2;
        int          n;
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; rwe[i] = 1'b0; raddr[i] = '0; rwd[i] = '0; rrdy[i] = 1'b1; seen[i] = 1'b0;
        end
        @(posedge clk); #1;
        chk_reset_outputs(0);
        chk_reset_outputs(1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Two-wait responder: basic write/read, misaligned and out-of-range errors.
        do_req(1, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, t);
        do_req(1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, t);
        do_req(1, 1'b1, 32'h12,  32'hBAD0BAD0, 32'h0,        1'b1, t);
        do_req(1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, t);
        do_req(1, 1'b0, 32'h100, 32'h0,        32'h0,        1'b1, t);
        do_req(1, 1'b1, 32'h100, 32'h55555555, 32'h0,        1'b1, t);
        do_req(1, 1'b1, 32'hFC,  32'hA5A5A5A5, 32'h0,        1'b0, t);
        do_req(1, 1'b0, 32'hFC,  32'h0,        32'hA5A5A5A5, 1'b0, t);
        do_req(1, 1'b0, 32'hFD,  32'h0,        32'h0,        1'b1, t);

        // Zero-wait responder: writes, then back-to-back reads.
        do_req(0, 1'b1, 32'h0,  32'h11111111, 32'h0,        1'b0, t);
        do_req(0, 1'b1, 32'h4,  32'h22222222, 32'h0,        1'b0, t);
        do_req(0, 1'b0, 32'h0,  32'h0,        32'h11111111, 1'b0, t1);
        do_req(0, 1'b0, 32'h4,  32'h0,        32'h22222222, 1'b0, t2);
        chk("accept_spacing", 0, t2 - t1, 32'd2);
        do_req(0, 1'b0, 32'h3,  32'h0,        32'h0,        1'b1, t);
        wait_idle();

        // Backpressure on the two-wait responder.
        rrdy[1] = 1'b0;
        do_req(1, 1'b0, 32'hFC, 32'h0, 32'hA5A5A5A5, 1'b0, t);
        n = 0;
        while (!resp_valid[1] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_resp_valid", 1, 32'(resp_valid[1]), 32'd1);
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        rrdy[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_ready", 1, 32'(req_ready[1]), 32'd1);
        chk("bp_release_valid", 1, 32'(resp_valid[1]), 32'd0);
        wait_idle();

        // Reset while a write is waiting must abort it.
        do_req(1, 1'b1, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, t);
        wait_idle();
        do_req(1, 1'b1, 32'h20, 32'h12345678, 32'h0, 1'b0, t);
        reset = 1'b1;
        #1;
        chk_reset_outputs(1);
        q1.delete();
        seen[1] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        do_req(1, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, t);
        do_req(0, 1'b0, 32'h4,  32'h0, 32'h22222222, 1'b0, t);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
